// File: rtl/fp8_pkg.sv
// Shared definitions for the fp8 (1s/4e/3m, bias 7) adder and its arbiter.
package fp8_pkg;

  localparam int SIGN_BIT = 7;
  localparam int EXP_MSB  = 6;
  localparam int EXP_LSB  = 3;
  localparam int MAN_MSB  = 2;
  localparam int MAN_LSB  = 0;
  localparam int EXP_BIAS = 7;

  localparam logic [7:0] FP8_QNAN = 8'h7F;
  localparam logic [7:0] FP8_PINF = 8'h78;
  localparam logic [7:0] FP8_ZERO = 8'h00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } fsm_state_e;

  function automatic logic fp8_is_nan(input logic [7:0] x);
    return (&x[EXP_MSB:EXP_LSB]) && (|x[MAN_MSB:MAN_LSB]);
  endfunction

  function automatic logic fp8_is_inf(input logic [7:0] x);
    return (&x[EXP_MSB:EXP_LSB]) && !(|x[MAN_MSB:MAN_LSB]);
  endfunction

endpackage

// File: rtl/fp8_add_core.sv
// Combinational fp8 adder: align with guard bit, add/sub, normalise, truncate.
// Exponent field 0 is treated as zero (no subnormals); underflow flushes to +0.
module fp8_add_core
  import fp8_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] sum
);

  logic       a_big;
  logic [7:0] lg, sm;
  logic [3:0] e_lg, e_sm, e_diff;
  logic [4:0] m_lg, m_sm, m_sh;
  logic [5:0] add_r;
  logic [4:0] sub_r, sub_n;
  logic [2:0] lz;
  logic       lz_found;
  logic [4:0] e_add, e_sub;

  // Exponent-major ordering lets one 7-bit compare pick the larger magnitude
  assign a_big  = (a[6:0] >= b[6:0]);
  assign lg     = a_big ? a : b;
  assign sm     = a_big ? b : a;
  assign e_lg   = lg[EXP_MSB:EXP_LSB];
  assign e_sm   = sm[EXP_MSB:EXP_LSB];
  assign e_diff = e_lg - e_sm;
  assign m_lg   = (e_lg == 4'd0) ? 5'd0 : {1'b1, lg[MAN_MSB:MAN_LSB], 1'b0};
  assign m_sm   = (e_sm == 4'd0) ? 5'd0 : {1'b1, sm[MAN_MSB:MAN_LSB], 1'b0};
  assign m_sh   = (e_diff > 4'd4) ? 5'd0 : (m_sm >> e_diff);

  assign add_r  = {1'b0, m_lg} + {1'b0, m_sh};
  assign sub_r  = m_lg - m_sh;

  always_comb begin
    lz       = 3'd0;
    lz_found = 1'b0;
    for (int i = 4; i >= 0; i--) begin
      if (!lz_found && sub_r[i]) begin
        lz_found = 1'b1;
        lz       = 3'(4 - i);
      end
    end
  end

  assign sub_n = sub_r << lz;
  assign e_add = {1'b0, e_lg} + {4'd0, add_r[5]};
  assign e_sub = {1'b0, e_lg} - {2'd0, lz};

  always_comb begin
    sum = FP8_ZERO;
    if (fp8_is_nan(a) || fp8_is_nan(b)) begin
      sum = FP8_QNAN;
    end else if (fp8_is_inf(a) || fp8_is_inf(b)) begin
      sum = {lg[SIGN_BIT], FP8_PINF[6:0]};
    end else if (lg[SIGN_BIT] == sm[SIGN_BIT]) begin
      if (add_r == 6'd0)
        sum = FP8_ZERO;
      else if (e_add >= 5'd15)
        sum = {lg[SIGN_BIT], FP8_PINF[6:0]};
      else
        sum = {lg[SIGN_BIT], e_add[3:0], add_r[5] ? add_r[4:2] : add_r[3:1]};
    end else begin
      // Borrow into bit 4 of e_sub, or a zero exponent, means underflow
      if (sub_r == 5'd0 || e_sub[4] || e_sub == 5'd0)
        sum = FP8_ZERO;
      else
        sum = {lg[SIGN_BIT], e_sub[3:0], sub_n[3:1]};
    end
  end

endmodule

// File: rtl/fp8_add_arbiter.sv
// Round-robin arbiter sharing one fp8_add_core among NUM_REQ requesters.
// Build option FP8_ARB_PRIO0_EN: requester 0 always wins when valid, pointer untouched.
module fp8_add_arbiter
  import fp8_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_a,
  input  logic [8*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 resp_valid,
  output logic [7:0]           resp_data,
  output logic [ID_W-1:0]      resp_id,
  input  logic                 resp_ready,
  output logic                 busy
);

  fsm_state_e      state;
  logic [ID_W-1:0] ptr;
  logic [7:0]      op_a, op_b, core_sum;
  logic [ID_W-1:0] cap_id;

  logic            grant_en, take, win_found, win_prio0;
  logic [ID_W-1:0] win_idx, ptr_next;
  logic [ID_W:0]   idx;

  assign grant_en = ena && ((state == IDLE) || (state == RESP && resp_ready));

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_prio0 = 1'b0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(NUM_REQ))
        idx = idx - (ID_W+1)'(NUM_REQ);
      if (!win_found && req_valid[idx[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = idx[ID_W-1:0];
      end
    end
`ifdef FP8_ARB_PRIO0_EN
    if (req_valid[0]) begin
      win_found = 1'b1;
      win_idx   = '0;
      win_prio0 = 1'b1;
    end
`endif
  end

  assign take     = grant_en && win_found;
  assign ptr_next = (win_idx == ID_W'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_rdy
    assign req_ready[g] = take && (win_idx == ID_W'(g));
  end

  fp8_add_core u_core (
    .a   (op_a),
    .b   (op_b),
    .sum (core_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      cap_id    <= '0;
      resp_data <= FP8_ZERO;
      resp_id   <= '0;
    end else begin
      if (take) begin
        op_a   <= req_a[8*win_idx +: 8];
        op_b   <= req_b[8*win_idx +: 8];
        cap_id <= win_idx;
        if (!win_prio0)
          ptr <= ptr_next;
      end
      case (state)
        IDLE: if (take) state <= EXEC;
        EXEC: begin
          resp_data <= core_sum;
          resp_id   <= cap_id;
          state     <= RESP;
        end
        RESP: if (resp_ready) state <= take ? EXEC : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_fp8_add_arbiter.sv
// Directed self-checking bench for fp8_add_arbiter (NUM_REQ=4).
module tb_fp8_add_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic [3:0]  req_valid;
  logic [31:0] req_a, req_b;
  logic [3:0]  req_ready;
  logic        resp_valid;
  logic [7:0]  resp_data;
  logic [1:0]  resp_id;
  logic        resp_ready;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;
  int rr_exp[5];

  fp8_add_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .resp_ready (resp_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge with the DUT idle; one requester, full handshake.
  task automatic run_op(input string tag, input int id, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] s);
    logic [3:0] oh;
    oh = 4'(1 << id);
    req_valid = oh;
    req_a[8*id +: 8] = a;
    req_b[8*id +: 8] = b;
    resp_ready = 1'b0;
    #1;
    chk({tag, "_rdy"}, 32'(req_ready), 32'(oh));
    tick();
    req_valid = 4'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_vld_t1"}, 32'(resp_valid), 32'd0);
    tick();
    chk({tag, "_vld_t2"}, 32'(resp_valid), 32'd1);
    chk({tag, "_data"}, 32'(resp_data), 32'(s));
    chk({tag, "_id"}, 32'(resp_id), 32'(id));
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk({tag, "_done"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
`ifdef FP8_ARB_PRIO0_EN
    rr_exp = '{0, 0, 0, 0, 0};
`else
    rr_exp = '{0, 1, 2, 3, 0};
`endif
    rst_n = 1'b0; ena = 1'b1; req_valid = '0; req_a = '0; req_b = '0; resp_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_rdy", 32'(req_ready), 32'd0);
    chk("rst_vld", 32'(resp_valid), 32'd0);
    chk("rst_data", 32'(resp_data), 32'd0);
    chk("rst_id", 32'(resp_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("one",   0, 8'h38, 8'h38, 8'h40);
    run_op("cancel",1, 8'h38, 8'hB8, 8'h00);
    run_op("nan",   2, 8'h79, 8'h38, 8'h7F);
    run_op("inf",   3, 8'h78, 8'h38, 8'h78);
    run_op("half",  0, 8'h38, 8'h30, 8'h3C);
    run_op("sub",   1, 8'h40, 8'hB8, 8'h38);
    run_op("ovf",   2, 8'h77, 8'h77, 8'h78);
    run_op("zero",  3, 8'h00, 8'h38, 8'h38);

    // Round robin with continuous acceptance; pointer is back at 0.
    req_a = {4{8'h38}}; req_b = {4{8'h38}};
    req_valid = 4'hF; resp_ready = 1'b1;
    #1;
    chk("rr_rdy0", 32'(req_ready), 32'd1);
    for (int n = 0; n < 5; n++) begin
      tick();
      tick();
      chk($sformatf("rr_vld%0d", n), 32'(resp_valid), 32'd1);
      chk($sformatf("rr_id%0d", n), 32'(resp_id), 32'(rr_exp[n]));
      chk($sformatf("rr_data%0d", n), 32'(resp_data), 32'h40);
    end
    req_valid = 4'h0;
    tick();
    resp_ready = 1'b0;
    chk("rr_idle", 32'(busy), 32'd0);

    // Backpressure on requester 2.
    req_valid = 4'b0100;
    #1;
    chk("bp_rdy", 32'(req_ready), 32'b0100);
    tick();
    req_valid = 4'hF;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_vld%0d", k), 32'(resp_valid), 32'd1);
      chk($sformatf("bp_data%0d", k), 32'(resp_data), 32'h40);
      chk($sformatf("bp_id%0d", k), 32'(resp_id), 32'd2);
      chk($sformatf("bp_rdy%0d", k), 32'(req_ready), 32'd0);
      tick();
    end
    req_valid = 4'h0; resp_ready = 1'b1;
    #1;
    chk("bp_acc_rdy", 32'(req_ready), 32'd0);
    tick();
    resp_ready = 1'b0;
    chk("bp_idle", 32'(busy), 32'd0);

    // Reset while in EXEC.
    req_valid = 4'b0010;
    tick();
    req_valid = 4'h0;
    chk("mr_exec", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_vld", 32'(resp_valid), 32'd0);
    chk("mr_data", 32'(resp_data), 32'd0);
    chk("mr_id", 32'(resp_id), 32'd0);
    chk("mr_rdy", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("mr_post%0d", k), 32'(resp_valid), 32'd0);
    end

    // Enable gating; pointer is 0 after reset.
    ena = 1'b0; req_valid = 4'hF;
    #1;
    chk("ena_rdy_off", 32'(req_ready), 32'd0);
    tick();
    chk("ena_busy_off", 32'(busy), 32'd0);
    ena = 1'b1;
    #1;
    chk("ena_rdy_on", 32'(req_ready), 32'd1);
    tick();
    ena = 1'b0;
    tick();
    chk("ena_inflight_vld", 32'(resp_valid), 32'd1);
    chk("ena_inflight_id", 32'(resp_id), 32'd0);
    resp_ready = 1'b1;
    #1;
    chk("ena_acc_rdy", 32'(req_ready), 32'd0);
    tick();
    chk("ena_end_busy", 32'(busy), 32'd0);
    resp_ready = 1'b0; req_valid = 4'h0; ena = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
